// File: rtl/mul_sp.sv
// Multi-cycle IEEE-754 single-precision multiplier: serial shift-add mantissa
// product, round-to-nearest-even, denormals flushed to zero, canonical NaN out.
module mul_sp #(
    parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        strt,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] o_z,
    output logic        o_done,
    output logic        o_busy
);

    typedef enum logic [2:0] {IDLE, UNPACK, SPECIAL, MULT, NORM, ROUND, DONE} state_t;

    state_t            state, nxt;
    logic [31:0]       ra, rb;
    logic              sz;
    logic [7:0]        ea, eb;
    logic [23:0]       ma, mb;
    logic              a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic signed [9:0] ez;
    logic [47:0]       prod, mcand;
    logic [23:0]       mplier;
    logic [4:0]        cnt;
    logic [23:0]       mant;
    logic              g, r, st;
    logic              special;
    logic              up;
    logic [24:0]       rsum;
    logic [22:0]       rm;
    logic signed [9:0] re;

    assign special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (strt) nxt = UNPACK;
            UNPACK:  nxt = SPECIAL;
            SPECIAL: nxt = special ? DONE : MULT;
            MULT:    if (cnt == 5'd23) nxt = NORM;
            NORM:    nxt = ROUND;
            ROUND:   nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        o_done = (state == DONE);
        o_busy = (state != IDLE);
    end

    // Nearest-even increment; a carry out of the mantissa renormalises by one.
    always_comb begin
        up   = g & (r | st | mant[0]);
        rsum = {1'b0, mant} + {24'd0, up};
        if (rsum[24]) begin
            rm = rsum[23:1];
            re = ez + 10'sd1;
        end else begin
            rm = rsum[22:0];
            re = ez;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ra <= '0; rb <= '0; sz <= 1'b0; ea <= '0; eb <= '0; ma <= '0; mb <= '0;
            a_zero <= 1'b0; a_inf <= 1'b0; a_nan <= 1'b0;
            b_zero <= 1'b0; b_inf <= 1'b0; b_nan <= 1'b0;
            ez <= '0; prod <= '0; mcand <= '0; mplier <= '0; cnt <= '0;
            mant <= '0; g <= 1'b0; r <= 1'b0; st <= 1'b0;
            o_z <= 32'h0;
        end else begin
            case (state)
                IDLE: if (strt) begin
                    ra <= a;
                    rb <= b;
                end
                UNPACK: begin
                    sz     <= ra[31] ^ rb[31];
                    ea     <= ra[30:23];
                    eb     <= rb[30:23];
                    ma     <= (ra[30:23] != 8'd0) ? {1'b1, ra[22:0]} : 24'd0;
                    mb     <= (rb[30:23] != 8'd0) ? {1'b1, rb[22:0]} : 24'd0;
                    a_zero <= (ra[30:23] == 8'd0);
                    b_zero <= (rb[30:23] == 8'd0);
                    a_inf  <= (ra[30:23] == 8'hFF) && (ra[22:0] == 23'd0);
                    b_inf  <= (rb[30:23] == 8'hFF) && (rb[22:0] == 23'd0);
                    a_nan  <= (ra[30:23] == 8'hFF) && (ra[22:0] != 23'd0);
                    b_nan  <= (rb[30:23] == 8'hFF) && (rb[22:0] != 23'd0);
                end
                SPECIAL: begin
                    ez     <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
                    mcand  <= {24'd0, ma};
                    mplier <= mb;
                    prod   <= '0;
                    cnt    <= '0;
                    if (a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf))
                        o_z <= CANON_NAN;
                    else if (a_inf | b_inf)
                        o_z <= {sz, 8'hFF, 23'd0};
                    else if (a_zero | b_zero)
                        o_z <= {sz, 31'd0};
                end
                MULT: begin
                    if (mplier[0]) prod <= prod + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 5'd1;
                end
                NORM: begin
                    // Product of two [1,2) mantissas lies in [1,4); bit 47 marks >= 2.
                    if (prod[47]) begin
                        mant <= prod[47:24];
                        g    <= prod[23];
                        r    <= prod[22];
                        st   <= |prod[21:0];
                        ez   <= ez + 10'sd1;
                    end else begin
                        mant <= prod[46:23];
                        g    <= prod[22];
                        r    <= prod[21];
                        st   <= |prod[20:0];
                    end
                end
                ROUND: begin
                    if (re >= 10'sd255)    o_z <= {sz, 8'hFF, 23'd0};
                    else if (re <= 10'sd0) o_z <= {sz, 31'd0};
                    else                   o_z <= {sz, re[7:0], rm};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_sp.sv
// Scoreboard bench for mul_sp: directed vectors, back-to-back starts, reset abort,
// and random operands checked against an integer-arithmetic float multiply model.
module tb_mul_sp;

    localparam logic [31:0] CANON = 32'h7FC00000;

    logic        clk = 1'b0, reset = 1'b0, strt = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic [31:0] o_z;
    logic        o_done, o_busy;

    mul_sp #(.CANON_NAN(CANON)) dut (
        .clk(clk), .reset(reset), .strt(strt), .a(a), .b(b),
        .o_z(o_z), .o_done(o_done), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] z;
        int          lat;
        int          t0;
        logic [31:0] x, y;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0, checks = 0, cyc = 0;
    bit          rst_smp;
    logic [31:0] last_z = '0;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rst_smp <= reset;
    end

    // Float multiply from the number rules: exact 48-bit product, then RNE by remainder.
    function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        logic s;
        int ex, ey, e, sh;
        longint unsigned mx, my, p, q, rem, half;
        logic [7:0] e8;
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        if ((ex == 255 && x[22:0] != 0) || (ey == 255 && y[22:0] != 0)) return CANON;
        if ((ex == 255 && ey == 0) || (ex == 0 && ey == 255)) return CANON;
        if (ex == 255 || ey == 255) return {s, 8'hFF, 23'h0};
        if (ex == 0 || ey == 0) return {s, 31'h0};
        mx = {40'd0, 1'b1, x[22:0]};
        my = {40'd0, 1'b1, y[22:0]};
        p  = mx * my;
        sh = (p >= (64'd1 << 47)) ? 24 : 23;
        e  = ex + ey - 127 + (sh - 23);
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0) return {s, 31'h0};
        e8 = e[7:0];
        return {s, e8, q[22:0]};
    endfunction

    function automatic int ref_lat(input logic [31:0] x, input logic [31:0] y);
        if (x[30:23] == 8'd0 || x[30:23] == 8'hFF || y[30:23] == 8'd0 || y[30:23] == 8'hFF)
            return 3;
        return 29;
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0] e;
        int k;
        k = int'($urandom_range(0, 11));
        case (k)
            0:       e = 8'd0;
            1, 2:    e = 8'hFF;
            3:       e = 8'(200 + $urandom_range(0, 54));
            4:       e = 8'(1 + $urandom_range(0, 59));
            default: e = 8'(100 + $urandom_range(0, 54));
        endcase
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    // Checker: reset state, one scoreboard entry per o_done, o_z held otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_smp) begin
            checks++;
            if (o_z !== 32'h0 || o_done !== 1'b0 || o_busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_state: o_z=%h done=%b busy=%b, required 0/0/0", o_z, o_done, o_busy);
            end
            last_z = 32'h0;
        end else if (o_done === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL spurious_done: o_done with no outstanding operation, o_z=%h", o_z);
            end else begin
                e = sb.pop_front();
                if (o_z !== e.z) begin
                    errors++;
                    $display("FAIL result a=%h b=%h: got %h required %h", e.x, e.y, o_z, e.z);
                end
                checks++;
                if (cyc - e.t0 != e.lat) begin
                    errors++;
                    $display("FAIL latency a=%h b=%h: got %0d required %0d", e.x, e.y, cyc - e.t0, e.lat);
                end
            end
            last_z = o_z;
        end else begin
            checks++;
            if (o_z !== last_z) begin
                errors++;
                $display("FAIL hold: o_z changed to %h without o_done, required %h", o_z, last_z);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the capturing edge.
    task automatic issue(input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] z, input int lat, input bit hold, input bit track);
        int n = 0;
        exp_t e;
        while (o_busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: o_busy=%b after %0d cycles, required 0", o_busy, n);
            return;
        end
        a = x;
        b = y;
        strt = 1'b1;
        if (track) begin
            e.z = z; e.lat = lat; e.t0 = cyc; e.x = x; e.y = y;
            sb.push_back(e);
        end
        @(negedge clk);
        if (!hold) strt = 1'b0;
        a = 32'($urandom);
        b = 32'($urandom);
    endtask

    task automatic issue_ref(input logic [31:0] x, input logic [31:0] y, input bit hold);
        issue(x, y, ref_mul(x, y), ref_lat(x, y), hold, 1'b1);
    endtask

    logic [31:0] dir_a[10] = '{32'h40000000, 32'h3FC00000, 32'hC0000000, 32'h7F800000, 32'hFF800000,
                               32'h7F000000, 32'h00800000, 32'h3F800001, 32'h3F800001, 32'h3F800003};
    logic [31:0] dir_b[10] = '{32'h40400000, 32'h3FC00000, 32'h3F000000, 32'h00000000, 32'h40000000,
                               32'h7F000000, 32'h00800000, 32'h3F800001, 32'h3FC00000, 32'h3FC00000};
    logic [31:0] dir_z[10] = '{32'h40C00000, 32'h40100000, 32'hBF800000, 32'h7FC00000, 32'hFF800000,
                               32'h7F800000, 32'h00000000, 32'h3F800002, 32'h3FC00002, 32'h3FC00004};
    int          dir_l[10] = '{29, 29, 29, 3, 3, 29, 29, 29, 29, 29};

    initial begin
        int n;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            issue(dir_a[i], dir_b[i], dir_z[i], dir_l[i], 1'b0, 1'b1);

        // strt held high: three back-to-back operations
        issue_ref(32'h40000000, 32'h40400000, 1'b1);
        issue_ref(32'h7F800000, 32'h3F800000, 1'b1);
        issue_ref(32'hBFC00000, 32'h3FC00000, 1'b0);

        // abort mid-MULT; the checker flags any o_done and verifies the reset state
        issue(32'h40000000, 32'h40000000, 32'h0, 0, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 60; i++)
            issue_ref(rand_fp(), rand_fp(), (i % 7) < 3);
        strt = 1'b0;

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
        end
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
